// File: rtl/spi_reg_frontend.sv
// SPI mode-0 register front end: decodes 16-bit {rw, addr, data} frames from
// pre-synchronised SPI levels into single-cycle register strobes; serialises read data.
module spi_reg_frontend #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8   // frame carries exactly one data byte; only 8 is supported
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic              spi_sclk,
   input  logic              spi_cs_n,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   output logic              reg_we,
   output logic              reg_re,
   input  logic [DATA_W-1:0] reg_rdata,
   output logic              frame_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                sclk_q, csn_q;
   logic [3:0]          bit_cnt_q, bit_cnt_d;
   logic [7:0]          shift_q, shift_d;
   logic                rw_q, rw_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   tx_q, tx_d;
   logic                we_q, we_d;
   logic                re_q, re_d;
   logic                load_q, load_d;
   logic                miso_q, miso_d;
   logic                err_q, err_d;

   logic                sclk_rise, sclk_fall, cs_start, cs_end;
   logic [7:0]          byte_in;

   assign sclk_rise = spi_sclk & ~sclk_q;
   assign sclk_fall = ~spi_sclk & sclk_q;
   assign cs_start  = csn_q & ~spi_cs_n;
   assign cs_end    = ~csn_q & spi_cs_n;
   assign byte_in   = {shift_q[6:0], spi_mosi};

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      rw_d      = rw_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      tx_d      = tx_q;
      we_d      = 1'b0;
      re_d      = 1'b0;
      err_d     = 1'b0;
      load_d    = re_q;
      miso_d    = miso_q;

      // Read data is captured the cycle after reg_re, when the bank has it valid.
      if (load_q) tx_d = reg_rdata;

      if (!ena) begin
         state_d = IDLE;
         load_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cs_start) begin
                  bit_cnt_d = 4'd0;
                  state_d   = CMD;
               end
            end
            CMD: begin
               if (cs_end) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else if (sclk_rise) begin
                  shift_d   = byte_in;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     addr_d  = byte_in[ADDR_W-1:0];
                     rw_d    = byte_in[7];
                     re_d    = ~byte_in[7];
                     state_d = DATA;
                  end
               end
            end
            DATA: begin
               if (cs_end) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  if (sclk_rise) begin
                     shift_d   = byte_in;
                     bit_cnt_d = bit_cnt_q + 4'd1;
                     if (bit_cnt_q == 4'd15) begin
                        if (rw_q) begin
                           wdata_d = byte_in;
                           we_d    = 1'b1;
                        end
                        state_d = DONE;
                     end
                  end
                  if (sclk_fall && !rw_q) begin
                     miso_d = tx_q[DATA_W-1];
                     tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                  end
               end
            end
            DONE: begin
               if (cs_end) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      if (state_d == IDLE || state_d == CMD) miso_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         sclk_q    <= 1'b0;
         csn_q     <= 1'b1;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         rw_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         tx_q      <= '0;
         we_q      <= 1'b0;
         re_q      <= 1'b0;
         load_q    <= 1'b0;
         miso_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sclk_q    <= spi_sclk;
         csn_q     <= spi_cs_n;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         rw_q      <= rw_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         tx_q      <= tx_d;
         we_q      <= we_d;
         re_q      <= re_d;
         load_q    <= load_d;
         miso_q    <= miso_d;
         err_q     <= err_d;
      end
   end

   assign spi_miso    = miso_q;
   assign spi_miso_oe = (state_q != IDLE);
   assign reg_addr    = addr_q;
   assign reg_wdata   = wdata_q;
   assign reg_we      = we_q;
   assign reg_re      = re_q;
   assign frame_err   = err_q;

endmodule

// File: doc/spi_reg_frontend.md
Name: spi_reg_frontend

Overview:
Protocol stage directly downstream of the SPI input reclocking/synchroniser. It consumes the already-synchronised SCLK/CS_N/MOSI levels, detects SCLK and CS_N edges in the system clock domain, and decodes 16-bit SPI mode-0 frames into single-cycle register read/write strobes. It also serialises read data onto MISO for the register bank that sits behind it.

Parameters:
ADDR_W, 3, register address width; valid range 1..7; command bits [6:ADDR_W] are ignored.
DATA_W, 8, register data width; fixed at 8 for this frame format, and any other value is unsupported.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
ena  input  1  block enable; low forces IDLE
spi_sclk  input  1  synchronised SCLK level
spi_cs_n  input  1  synchronised chip select, active low
spi_mosi  input  1  synchronised MOSI level
spi_miso  output  1  serial read data
spi_miso_oe  output  1  MISO output enable; high while a frame is active
reg_addr  output  ADDR_W  latched register address
reg_wdata  output  DATA_W  latched write data
reg_we  output  1  one-cycle write strobe
reg_re  output  1  one-cycle read strobe
reg_rdata  input  DATA_W  read data; must be valid in the cycle after reg_re
frame_err  output  1  one-cycle pulse on a truncated frame

Behaviour:
- Reset values: all outputs 0. Internal registers: sclk_q=0, csn_q=1, state=IDLE, counters 0.
- Edge detection: sclk_q and csn_q are registered every clk.
  - sclk_rise = spi_sclk & ~sclk_q; sclk_fall = ~spi_sclk & sclk_q.
  - cs_start = csn_q & ~spi_cs_n; cs_end = ~csn_q & spi_cs_n.
  - An edge is detected combinationally in cycle N. Every registered action it causes is visible in cycle N+1.
- Input constraint: SCLK high and low phases each last at least 3 clk periods.
- Frame format: MSB first, sampled on sclk_rise.
  - Byte 0 = {rw, addr[6:0]}, where rw=1 is a write.
  - Byte 1 = write data (write frame) or don't-care (read frame).
- States:
  - IDLE: waits for cs_start, then clears the bit counter and enters CMD.
  - CMD: shifts in 8 bits. On the 8th sclk_rise it latches reg_addr=addr[ADDR_W-1:0] and rw, then enters DATA.
    - For a read, reg_re pulses in N+1. In N+2 reg_rdata is loaded into the tx shift register.
  - DATA: shifts in 8 bits.
    - For a read, each sclk_fall drives spi_miso from tx[7] and shifts tx left. The first fall after the 8th command rise presents rdata[7].
    - On the 16th sclk_rise of a write, reg_wdata is latched and reg_we pulses in N+1 with a stable reg_addr/reg_wdata.
    - After the 16th rise, enter DONE.
  - DONE: ignores SCLK and MOSI until cs_end, then returns to IDLE.
- spi_miso is 0 in IDLE and CMD, and 0 in DATA for write frames. spi_miso_oe = (state != IDLE).
- cs_end in CMD or DATA: frame_err pulses in N+1, no reg_we is issued, and the state returns to IDLE. A reg_re already issued is not retracted.
- cs_end in DONE: no error.
- cs_end and sclk_rise in the same cycle: cs_end wins and the bit is discarded.
- ena=0: forces IDLE next cycle with no frame_err, and no strobes are produced. sclk_q/csn_q keep tracking. A frame already in progress when ena rises is ignored until the next cs_start.
- cs_start while not IDLE: cannot occur without a prior cs_end; no special handling.
- rst asserted mid-frame: everything returns to reset values immediately, with no strobes.
- reg_addr and reg_wdata hold their last values between frames.

Test Plan:
- Write: CS low, MOSI 0x83 then 0xA5 (16 SCLKs), CS high -> exactly one reg_we cycle with reg_addr=3, reg_wdata=0xA5; reg_re and frame_err stay 0.
- Read: MOSI 0x05, 0x00 with reg_rdata=0x3C -> one reg_re pulse with reg_addr=5; MISO sampled on the 8 data rises = 0,0,1,1,1,1,0,0; spi_miso_oe=1 only while CS is low.
- Truncation: write frame 0x81, 0xFF aborted by CS high after 12 SCLKs -> frame_err pulses for 1 cycle, no reg_we, state IDLE; the next full frame works.
- Overrun: 20 SCLKs in one write frame 0x82, 0x11 -> single reg_we with addr=2, wdata=0x11; extra clocks are ignored and there is no frame_err.
- Enable/reset: ena=0 during a full write frame -> no strobes. rst pulse after 10 SCLKs -> outputs 0, no reg_we; the following frame decodes correctly.
- Address masking (ADDR_W=3): command 0xFE -> reg_addr=6, write performed.
